// File: rtl/vjtag_dr_bank.sv
// ---------------------------------------------------------------------------
// vjtag_dr_bank
//
// Data-register bank on the user side of a Virtual JTAG hub. It runs entirely
// in the tck domain. The virtual IR selects one of NUM_REGS data registers or
// a 1-bit BYPASS register. Registers are captured from cap_data, shifted LSB
// first, and updated into upd_data with a one-cycle strobe.
//
// Every shifted bit is counted. An Update-DR after a scan that was not
// exactly DR_WIDTH bits long is rejected. The rejection is reported through
// ir_out and leaves the control words unchanged.
//
// Ports:
//   tck                 in   clock, virtual JTAG tck
//   reset               in   synchronous, active-high reset
//   tdi                 in   serial data from the hub
//   tdo                 out  serial data to the hub (combinational)
//   ir_in               in   current virtual IR (opcode)
//   ir_out              out  status for Capture-IR: [0]=err_sticky,
//                            [1]=an update has been accepted since reset
//   virtual_state_cdr   in   Capture-DR
//   virtual_state_sdr   in   Shift-DR
//   virtual_state_udr   in   Update-DR
//   virtual_state_uir   in   Update-IR (clears err_sticky)
//   cap_data            in   parallel status words, word i at [i*DR_WIDTH +: DR_WIDTH]
//   upd_data            out  latched control words, same packing
//   upd_strobe          out  one-cycle pulse per register on an accepted update
// ---------------------------------------------------------------------------
module vjtag_dr_bank #(
    parameter int unsigned          IR_WIDTH = 5,
    parameter int unsigned          DR_WIDTH = 32,
    parameter int unsigned          NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0]  RO_MASK  = '0
) (
    input  logic                         tck,
    input  logic                         reset,
    input  logic                         tdi,
    output logic                         tdo,
    input  logic [IR_WIDTH-1:0]          ir_in,
    output logic [IR_WIDTH-1:0]          ir_out,
    input  logic                         virtual_state_cdr,
    input  logic                         virtual_state_sdr,
    input  logic                         virtual_state_udr,
    input  logic                         virtual_state_uir,
    input  logic [NUM_REGS*DR_WIDTH-1:0] cap_data,
    output logic [NUM_REGS*DR_WIDTH-1:0] upd_data,
    output logic [NUM_REGS-1:0]          upd_strobe
);

    // The bit counter must reach DR_WIDTH+1 so that over-long scans stay
    // distinguishable from exact ones.
    localparam int unsigned       CntW    = $clog2(DR_WIDTH + 2);
    localparam logic [CntW-1:0]   CntFull = CntW'(DR_WIDTH);
    localparam logic [CntW-1:0]   CntSat  = CntW'(DR_WIDTH + 1);

    // State
    logic [DR_WIDTH-1:0]          r_shift;
    logic                         r_bypass;
    logic [CntW-1:0]              r_bit_cnt;
    logic                         r_err_sticky;
    logic                         r_upd_seen;
    logic [NUM_REGS*DR_WIDTH-1:0] r_upd_data;
    logic [NUM_REGS-1:0]          r_upd_strobe;

    // Decode
    logic [NUM_REGS-1:0]          w_hit;
    logic                         w_sel_valid;
    logic [DR_WIDTH-1:0]          w_cap_word;
    logic                         w_len_ok;
    logic [NUM_REGS-1:0]          w_accept;
    logic                         w_len_err;

    // Opcode i+1 selects register i. Opcode 0 and every opcode above
    // NUM_REGS fall through to BYPASS.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            w_hit[i] = (ir_in == IR_WIDTH'(i + 1));
        end
    end

    assign w_sel_valid = |w_hit;

    always_comb begin
        w_cap_word = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_hit[i]) begin
                w_cap_word = cap_data[i*DR_WIDTH +: DR_WIDTH];
            end
        end
    end

    // bit_cnt is used as-is on Update-DR, even if no Capture-DR preceded
    // it. A repeated UDR after a good scan is therefore accepted again.
    assign w_len_ok  = (r_bit_cnt == CntFull);
    assign w_accept  = w_hit & ~RO_MASK & {NUM_REGS{virtual_state_udr & w_len_ok}};
    // The length check also applies to read-only registers. BYPASS never errors.
    assign w_len_err = virtual_state_udr & w_sel_valid & ~w_len_ok;

    always_ff @(posedge tck) begin
        if (reset) begin
            r_shift      <= '0;
            r_bypass     <= 1'b0;
            r_bit_cnt    <= '0;
            r_err_sticky <= 1'b0;
            r_upd_seen   <= 1'b0;
            r_upd_data   <= '0;
            r_upd_strobe <= '0;
        end else begin
            r_upd_strobe <= w_accept;

            if (virtual_state_cdr) begin
                if (w_sel_valid) begin
                    r_shift <= w_cap_word;
                end else begin
                    r_bypass <= 1'b0;
                end
                r_bit_cnt <= '0;
            end else if (virtual_state_sdr) begin
                if (w_sel_valid) begin
                    r_shift <= {tdi, r_shift[DR_WIDTH-1:1]};
                end else begin
                    r_bypass <= tdi;
                end
                if (r_bit_cnt != CntSat) begin
                    r_bit_cnt <= r_bit_cnt + CntW'(1);
                end
            end

            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_accept[i]) begin
                    r_upd_data[i*DR_WIDTH +: DR_WIDTH] <= r_shift;
                end
            end

            if (|w_accept) begin
                r_upd_seen <= 1'b1;
            end

            // A concurrent Update-IR wins over a new length error. The host
            // has already read the flag on the preceding Capture-IR.
            if (virtual_state_uir) begin
                r_err_sticky <= 1'b0;
            end else if (w_len_err) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign tdo        = w_sel_valid ? r_shift[0] : r_bypass;
    assign upd_data   = r_upd_data;
    assign upd_strobe = r_upd_strobe;

    always_comb begin
        ir_out    = '0;
        ir_out[0] = r_err_sticky;
        ir_out[1] = r_upd_seen;
    end

endmodule

// File: tb/tb_vjtag_dr_bank.sv
// ---------------------------------------------------------------------------
// tb_vjtag_dr_bank
//
// Directed testbench for vjtag_dr_bank with the default sizes and register 3
// made read-only. Inputs change on the falling edge of tck. Outputs are
// sampled on the falling edge, which reflects the state after the preceding
// rising edge.
// ---------------------------------------------------------------------------
module tb_vjtag_dr_bank;

    localparam int unsigned IR_W = 5;
    localparam int unsigned DR_W = 32;
    localparam int unsigned NR   = 4;

    logic                 tck = 1'b0;
    logic                 reset;
    logic                 tdi;
    logic                 tdo;
    logic [IR_W-1:0]      ir_in;
    logic [IR_W-1:0]      ir_out;
    logic                 cdr, sdr, udr, uir;
    logic [NR*DR_W-1:0]   cap_data;
    logic [NR*DR_W-1:0]   upd_data;
    logic [NR-1:0]        upd_strobe;

    int checks   = 0;
    int failures = 0;

    always #5 tck = ~tck;

    vjtag_dr_bank #(
        .IR_WIDTH (IR_W),
        .DR_WIDTH (DR_W),
        .NUM_REGS (NR),
        .RO_MASK  (4'b1000)
    ) dut (
        .tck               (tck),
        .reset             (reset),
        .tdi               (tdi),
        .tdo               (tdo),
        .ir_in             (ir_in),
        .ir_out            (ir_out),
        .virtual_state_cdr (cdr),
        .virtual_state_sdr (sdr),
        .virtual_state_udr (udr),
        .virtual_state_uir (uir),
        .cap_data          (cap_data),
        .upd_data          (upd_data),
        .upd_strobe        (upd_strobe)
    );

    task automatic step();
        @(negedge tck);
    endtask

    task automatic do_cdr();
        cdr = 1'b1;
        step();
        cdr = 1'b0;
    endtask

    task automatic do_shift(input int n, input logic [63:0] pat);
        for (int i = 0; i < n; i++) begin
            tdi = pat[i];
            sdr = 1'b1;
            step();
        end
        sdr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic do_udr();
        udr = 1'b1;
        step();
        udr = 1'b0;
    endtask

    task automatic do_uir();
        uir = 1'b1;
        step();
        uir = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (upd_data !== '0) begin
            failures++;
            $display("FAIL reset_upd_data got=%h exp=0", upd_data);
        end
        checks++;
        if (upd_strobe !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobe got=%b exp=0000", upd_strobe);
        end
        checks++;
        if (ir_out !== 5'b00000 || tdo !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got ir_out=%b tdo=%b exp 00000/0", ir_out, tdo);
        end
    endtask

    task automatic test_write();
        ir_in = 5'd2;
        do_cdr();
        do_shift(32, 64'hDEADBEEF);
        do_udr();
        checks++;
        if (upd_data[63:32] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_word1 got=%h exp=deadbeef", upd_data[63:32]);
        end
        checks++;
        if (upd_strobe !== 4'b0010) begin
            failures++;
            $display("FAIL write_strobe got=%b exp=0010", upd_strobe);
        end
        checks++;
        if (upd_data[31:0] !== 32'h0 || upd_data[127:64] !== 64'h0) begin
            failures++;
            $display("FAIL write_others got=%h exp=only word1 set", upd_data);
        end
        checks++;
        if (ir_out !== 5'b00010) begin
            failures++;
            $display("FAIL write_ir_out got=%b exp=00010", ir_out);
        end
        step();
        checks++;
        if (upd_strobe !== 4'b0000) begin
            failures++;
            $display("FAIL write_strobe_drop got=%b exp=0000", upd_strobe);
        end
    endtask

    task automatic test_read();
        logic [31:0] cap_w;
        logic [31:0] in_w;
        int          bad;
        cap_w = 32'h12345678;
        in_w  = 32'hCAFEF00D;
        bad   = 0;
        cap_data[31:0] = cap_w;
        ir_in = 5'd1;
        do_cdr();
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (tdo !== cap_w[k]) begin
                failures++;
                $display("FAIL read_tdo bit=%0d got=%b exp=%b", k, tdo, cap_w[k]);
            end
            tdi = in_w[k];
            sdr = 1'b1;
            step();
        end
        sdr = 1'b0;
        do_udr();
        checks++;
        if (upd_data[31:0] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL read_word0 got=%h exp=cafef00d", upd_data[31:0]);
        end
        checks++;
        if (upd_strobe !== 4'b0001 || upd_data[63:32] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_strobe_word1 got strobe=%b w1=%h exp 0001/deadbeef",
                     upd_strobe, upd_data[63:32]);
        end
    endtask

    task automatic test_back_to_back();
        ir_in = 5'd1;
        do_cdr();
        do_shift(32, 64'h0F0F0F0F);
        do_udr();
        checks++;
        if (upd_data[31:0] !== 32'h0F0F0F0F || upd_strobe !== 4'b0001) begin
            failures++;
            $display("FAIL b2b_first got w0=%h strobe=%b exp 0f0f0f0f/0001",
                     upd_data[31:0], upd_strobe);
        end
        do_cdr();
        do_shift(32, 64'h11223344);
        do_udr();
        checks++;
        if (upd_data[31:0] !== 32'h11223344 || upd_strobe !== 4'b0001) begin
            failures++;
            $display("FAIL b2b_second got w0=%h strobe=%b exp 11223344/0001",
                     upd_data[31:0], upd_strobe);
        end
        // The UDR below has no preceding CDR, so it sees bit_cnt left at 32.
        step();
        do_udr();
        checks++;
        if (upd_strobe !== 4'b0001 || ir_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stale_cnt got strobe=%b err=%b exp 0001/0",
                     upd_strobe, ir_out[0]);
        end
    endtask

    task automatic test_bypass();
        logic [IR_W-1:0] ops [3];
        logic [3:0]      seq;
        logic            prev;
        ops[0] = 5'd0;
        ops[1] = 5'd7;
        ops[2] = 5'd5;
        seq    = 4'b1101; // shifted LSB first: 1,0,1,1
        for (int o = 0; o < 3; o++) begin
            ir_in = ops[o];
            do_cdr();
            prev = 1'b0;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (tdo !== prev) begin
                    failures++;
                    $display("FAIL bypass_tdo op=%0d bit=%0d got=%b exp=%b", ops[o], k, tdo, prev);
                end
                tdi  = seq[k];
                sdr  = 1'b1;
                step();
                prev = seq[k];
            end
            sdr = 1'b0;
            checks++;
            if (tdo !== 1'b1) begin
                failures++;
                $display("FAIL bypass_tdo_last op=%0d got=%b exp=1", ops[o], tdo);
            end
            do_udr();
            checks++;
            if (upd_strobe !== 4'b0000 || ir_out !== 5'b00010 ||
                upd_data !== 128'h00000000_00000000_DEADBEEF_11223344) begin
                failures++;
                $display("FAIL bypass_udr op=%0d got strobe=%b ir_out=%b data=%h", ops[o],
                         upd_strobe, ir_out, upd_data);
            end
        end
    endtask

    task automatic test_short_long();
        int lens [2];
        lens[0] = 31;
        lens[1] = 33;
        ir_in = 5'd3;
        for (int l = 0; l < 2; l++) begin
            do_cdr();
            do_shift(lens[l], 64'h1_FFFF_FFFF);
            do_udr();
            checks++;
            if (upd_strobe !== 4'b0000 || upd_data[95:64] !== 32'h0) begin
                failures++;
                $display("FAIL badlen_reject len=%0d got strobe=%b w2=%h exp 0000/0",
                         lens[l], upd_strobe, upd_data[95:64]);
            end
            checks++;
            if (ir_out[0] !== 1'b1) begin
                failures++;
                $display("FAIL badlen_err len=%0d got=%b exp=1", lens[l], ir_out[0]);
            end
            do_uir();
            checks++;
            if (ir_out[0] !== 1'b0) begin
                failures++;
                $display("FAIL badlen_uir_clear len=%0d got=%b exp=0", lens[l], ir_out[0]);
            end
        end
    endtask

    task automatic test_read_only();
        ir_in = 5'd4;
        do_cdr();
        do_shift(32, 64'hA5A5A5A5);
        do_udr();
        checks++;
        if (upd_strobe !== 4'b0000 || upd_data[127:96] !== 32'h0) begin
            failures++;
            $display("FAIL ro_write got strobe=%b w3=%h exp 0000/0", upd_strobe, upd_data[127:96]);
        end
        checks++;
        if (ir_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL ro_no_err got=%b exp=0", ir_out[0]);
        end
        do_cdr();
        do_shift(31, 64'hA5A5A5A5);
        do_udr();
        checks++;
        if (ir_out[0] !== 1'b1 || upd_strobe !== 4'b0000) begin
            failures++;
            $display("FAIL ro_badlen got err=%b strobe=%b exp 1/0000", ir_out[0], upd_strobe);
        end
        do_uir();
    endtask

    task automatic test_udr_uir_together();
        ir_in = 5'd3;
        do_cdr();
        do_shift(5, 64'h1F);
        udr = 1'b1;
        uir = 1'b1;
        step();
        udr = 1'b0;
        uir = 1'b0;
        checks++;
        if (ir_out[0] !== 1'b0 || upd_strobe !== 4'b0000) begin
            failures++;
            $display("FAIL udr_uir got err=%b strobe=%b exp 0/0000", ir_out[0], upd_strobe);
        end
    endtask

    task automatic test_reset_midscan();
        ir_in = 5'd1;
        do_cdr();
        do_shift(10, 64'h3FF);
        reset = 1'b1;
        udr   = 1'b1;
        step();
        reset = 1'b0;
        udr   = 1'b0;
        checks++;
        if (upd_data !== '0 || upd_strobe !== 4'b0000) begin
            failures++;
            $display("FAIL midscan_outputs got data=%h strobe=%b exp 0/0000", upd_data, upd_strobe);
        end
        checks++;
        if (ir_out !== 5'b00000 || tdo !== 1'b0) begin
            failures++;
            $display("FAIL midscan_status got ir_out=%b tdo=%b exp 00000/0", ir_out, tdo);
        end
        step();
        checks++;
        if (upd_strobe !== 4'b0000) begin
            failures++;
            $display("FAIL midscan_strobe_late got=%b exp=0000", upd_strobe);
        end
    endtask

    initial begin
        reset    = 1'b1;
        tdi      = 1'b0;
        ir_in    = '0;
        cdr      = 1'b0;
        sdr      = 1'b0;
        udr      = 1'b0;
        uir      = 1'b0;
        cap_data = '0;
        step();
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_bypass();
        test_short_long();
        test_read_only();
        test_udr_uir_together();
        test_reset_midscan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vjtag_dr_bank.md
Name: vjtag_dr_bank

Overview:
- User-side data-register bank behind the Virtual JTAG hub, running in the tck domain.
- Decodes the virtual IR into one of NUM_REGS data registers or a 1-bit BYPASS.
- Handles capture/shift/update. Latches parallel control words with a one-cycle strobe.
- Counts shifted bits, so a short or long DR scan is rejected and flagged through ir_out instead of corrupting control state.

Parameters:
- IR_WIDTH, 5: virtual IR width; must hold NUM_REGS+1 opcodes.
- DR_WIDTH, 32: width of each data register; minimum 2.
- NUM_REGS, 4: number of data registers, 1..2**IR_WIDTH-1.
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only.

Ports:
- tck  in  1: clock (virtual JTAG tck); the only clock.
- reset  in  1: synchronous, active-high reset.
- tdi  in  1: serial data in from hub.
- tdo  out  1: serial data out to hub.
- ir_in  in  IR_WIDTH: current virtual IR.
- ir_out  out  IR_WIDTH: status captured into IR on CIR.
- virtual_state_cdr  in  1: Capture-DR.
- virtual_state_sdr  in  1: Shift-DR.
- virtual_state_udr  in  1: Update-DR.
- virtual_state_uir  in  1: Update-IR.
- cap_data  in  NUM_REGS*DR_WIDTH: parallel status words; register i occupies [i*DR_WIDTH +: DR_WIDTH].
- upd_data  out  NUM_REGS*DR_WIDTH: latched control words, same packing.
- upd_strobe  out  NUM_REGS: one-cycle pulse per register on accepted update.

Behaviour:
- Clock and reset: one clock, tck. Reset is synchronous and active-high.
- Values after reset:
  - upd_data = 0, upd_strobe = 0.
  - Shift register = 0, bypass bit = 0.
  - bit_cnt = 0, err_sticky = 0.
  - tdo = 0, ir_out = 0.
- Reset mid-scan aborts the scan. No update or strobe is issued.
- Opcode decode (combinational from ir_in):
  - 0 → BYPASS.
  - 1..NUM_REGS → register index ir_in-1.
  - Any other value → BYPASS.
- Capture-DR cycle (cdr=1):
  - Selected register: shift_reg <= its cap_data word.
  - BYPASS: bypass bit <= 0.
  - bit_cnt <= 0.
- Shift-DR cycle (sdr=1), LSB first:
  - Selected register: shift_reg <= {tdi, shift_reg[DR_WIDTH-1:1]}.
  - BYPASS: bypass bit <= tdi.
  - bit_cnt increments, saturating at DR_WIDTH+1.
- tdo is combinational: shift_reg[0] when a register is selected, bypass bit in BYPASS. Zero latency relative to the shifted state.
- Update-DR cycle (udr=1) on register i:
  - Accepted when bit_cnt == DR_WIDTH and RO_MASK[i] = 0. Then upd_data word i <= shift_reg, and upd_strobe[i] = 1 on the following cycle only.
  - Rejected when bit_cnt != DR_WIDTH. upd_data is unchanged, no strobe, and err_sticky <= 1.
  - RO_MASK[i] = 1: never updates and never strobes. A correct-length scan sets no error; a wrong length still sets err_sticky.
- Update-DR in BYPASS: no effect, no error.
- Accepted update latency:
  - upd_data changes on the tck edge ending the UDR cycle.
  - upd_strobe is high for exactly the next cycle.
  - Other registers' words are untouched.
- ir_out:
  - ir_out[0] = err_sticky; ir_out[1] = 1 when the last accepted update hit any register since reset (sticky).
  - All other bits are 0.
- Clearing err_sticky: cleared on a uir cycle, i.e. after the host has captured it on the preceding CIR.
- Simultaneous events:
  - cdr, sdr and udr are mutually exclusive in the TAP.
  - If both udr and uir are asserted, udr is processed first, then err_sticky is cleared (the uir clear wins).
  - reset overrides all.
- A stale bit_cnt with no CDR before UDR (bit_cnt from the previous scan) is evaluated as-is.
- Back-to-back scans need no idle cycles.

Test Plan:
- Write: ir_in=2, CDR, 32 SDR cycles shifting 0xDEADBEEF LSB first, UDR → upd_data[63:32]=0xDEADBEEF on the next edge; upd_strobe=4'b0010 for one cycle; other words stay 0.
- Read: cap_data word0=0x12345678, ir_in=1, CDR, 32 SDR → tdo sequence 0,0,0,1,1,1,1,0,... (0x12345678 LSB first); after UDR, upd_data word0 equals the tdi pattern shifted in.
- Short scan: ir_in=3, CDR, 31 SDR, UDR → no strobe, word2 unchanged, next CIR shows ir_out[0]=1; after a UIR, ir_out[0]=0. Repeat with 33 SDR cycles → same result.
- Bypass: ir_in=0, then ir_in=7 (NUM_REGS=4); shift 1,0,1,1 → tdo is tdi delayed one cycle (x,1,0,1); UDR → no strobe, no error.
- Read-only: RO_MASK=4'b1000, ir_in=4, 32-bit write of 0xA5A5A5A5 → word3 stays 0, no strobe, ir_out[0]=0.
- Reset mid-scan: assert reset after 10 SDR cycles, then UDR → all outputs 0, no strobe, err_sticky=0.
